// File: rtl/bp_fe_instr_realigner_if.sv
// Fetch-to-decode parcel bus: fetch words in, aligned 16/32-bit instructions out.
// Signal names are seen from the realigner's side.
interface bp_fe_instr_realigner_if #(
  parameter int unsigned vaddr_width_p = 39
);
  logic                     flush_i;
  logic                     fetch_v_i;
  logic [31:0]              fetch_data_i;
  logic [vaddr_width_p-1:0] fetch_pc_i;
  logic                     fetch_ready_o;
  logic                     instr_v_o;
  logic [31:0]              instr_o;
  logic [vaddr_width_p-1:0] instr_pc_o;
  logic                     instr_compressed_o;
  logic                     instr_yumi_i;

  // Upstream fetch unit plus downstream decoder.
  modport master (
    output flush_i, fetch_v_i, fetch_data_i, fetch_pc_i, instr_yumi_i,
    input  fetch_ready_o, instr_v_o, instr_o, instr_pc_o, instr_compressed_o
  );

  // Realigner.
  modport slave (
    input  flush_i, fetch_v_i, fetch_data_i, fetch_pc_i, instr_yumi_i,
    output fetch_ready_o, instr_v_o, instr_o, instr_pc_o, instr_compressed_o
  );
endinterface

// File: rtl/bp_fe_instr_realigner.sv
// Splits 32-bit fetch words into RVC/RV32 instructions, stitching 32-bit
// instructions that straddle a word boundary via a pending high parcel.
module bp_fe_instr_realigner #(
  parameter int unsigned vaddr_width_p = 39
) (
  input logic                     clk_i,
  input logic                     reset_n_i,
  bp_fe_instr_realigner_if.slave  bus
);

  localparam int unsigned parcel_w = 16;
  localparam int unsigned word_w   = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LO    = 2'd1,
    HI    = 2'd2,
    PEND  = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic [word_w-1:0]        word_q;
  logic [vaddr_width_p-1:0] word_pc_q;
  logic [parcel_w-1:0]      pend_q;
  logic [vaddr_width_p-1:0] pend_pc_q;

  logic                     load_word_c;
  logic                     load_pend_c;
  logic                     go_empty_c;
  logic                     fetch_ready_c;
  logic                     instr_v_c;
  logic [word_w-1:0]        instr_c;
  logic [vaddr_width_p-1:0] instr_pc_c;
  logic                     instr_compressed_c;

  logic                     lo_is_rvc;
  logic                     hi_is_rvc;
  logic [vaddr_width_p-1:0] word_pc_inc;

  assign lo_is_rvc   = (word_q[1:0]   != 2'b11);
  assign hi_is_rvc   = (word_q[17:16] != 2'b11);
  assign word_pc_inc = word_pc_q + vaddr_width_p'(2);

  // Next-state and output decode; flush and reset override everything.
  always_comb begin
    state_d            = state_q;
    load_word_c        = 1'b0;
    load_pend_c        = 1'b0;
    go_empty_c         = 1'b0;
    fetch_ready_c      = 1'b0;
    instr_v_c          = 1'b0;
    instr_c            = '0;
    instr_pc_c         = word_pc_q;
    instr_compressed_c = 1'b0;

    case (state_q)
      EMPTY: go_empty_c = 1'b1;
      LO: begin
        instr_v_c = 1'b1;
        if (lo_is_rvc) begin
          instr_c            = {16'h0000, word_q[15:0]};
          instr_compressed_c = 1'b1;
          if (bus.instr_yumi_i) state_d = HI;
        end else begin
          instr_c = word_q;
          if (bus.instr_yumi_i) go_empty_c = 1'b1;
        end
      end
      HI: begin
        if (hi_is_rvc) begin
          instr_v_c          = 1'b1;
          instr_c            = {16'h0000, word_q[31:16]};
          instr_pc_c         = word_pc_inc;
          instr_compressed_c = 1'b1;
          if (bus.instr_yumi_i) go_empty_c = 1'b1;
        end else begin
          // Upper parcel starts a 32-bit instruction: wait for the next word.
          fetch_ready_c = 1'b1;
          if (bus.fetch_v_i) begin
            load_word_c = 1'b1;
            load_pend_c = 1'b1;
            state_d     = PEND;
          end
        end
      end
      PEND: begin
        instr_v_c  = 1'b1;
        instr_c    = {word_q[15:0], pend_q};
        instr_pc_c = pend_pc_q;
        if (bus.instr_yumi_i) state_d = HI;
      end
      default: state_d = EMPTY;
    endcase

    // Word fully consumed: accept a new one in the same edge.
    if (go_empty_c) begin
      fetch_ready_c = 1'b1;
      state_d       = EMPTY;
      if (bus.fetch_v_i) begin
        load_word_c = 1'b1;
        state_d     = bus.fetch_pc_i[1] ? HI : LO;
      end
    end

    if (bus.flush_i || !reset_n_i) begin
      state_d       = EMPTY;
      load_word_c   = 1'b0;
      load_pend_c   = 1'b0;
      fetch_ready_c = 1'b0;
      instr_v_c     = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= EMPTY;
    else            state_q <= state_d;
  end

  // Parcel datapath; word_pc is kept word-aligned so the high half sits at +2.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      word_q    <= '0;
      word_pc_q <= '0;
      pend_q    <= '0;
      pend_pc_q <= '0;
    end else begin
      if (load_pend_c) begin
        pend_q    <= word_q[31:16];
        pend_pc_q <= word_pc_inc;
      end
      if (load_word_c) begin
        word_q    <= bus.fetch_data_i;
        word_pc_q <= bus.fetch_pc_i & ~vaddr_width_p'(3);
      end
    end
  end

  assign bus.fetch_ready_o      = fetch_ready_c;
  assign bus.instr_v_o          = instr_v_c;
  assign bus.instr_o            = instr_c;
  assign bus.instr_pc_o         = instr_pc_c;
  assign bus.instr_compressed_o = instr_compressed_c;

endmodule

// File: tb/tb_bp_fe_instr_realigner.sv
// Scoreboard bench for bp_fe_instr_realigner: a parcel-level reference stream
// supplies expected instructions, compared on every consumer handshake.
module tb_bp_fe_instr_realigner;

  localparam int unsigned VA = 39;
  typedef logic [VA-1:0] pc_t;
  typedef struct packed {logic [31:0] data; pc_t pc;} word_t;
  typedef struct packed {logic [31:0] instr; pc_t pc; logic comp;} exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bp_fe_instr_realigner_if #(.vaddr_width_p(VA)) bus();

  bp_fe_instr_realigner #(.vaddr_width_p(VA)) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus)
  );

  word_t       word_q[$];
  exp_t        exp_q[$];
  int unsigned fire_cyc[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;
  int          yumi_pct  = 100;
  int          fetch_pct = 100;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic quiet();
    bus.fetch_v_i    = 1'b0;
    bus.instr_yumi_i = 1'b0;
    bus.fetch_data_i = '0;
    bus.fetch_pc_i   = '0;
  endtask

  task automatic push_word(input logic [31:0] data, input pc_t pc);
    word_t w;
    w.data = data;
    w.pc   = pc;
    word_q.push_back(w);
  endtask

  task automatic push_exp(input logic [31:0] instr, input pc_t pc, input logic comp);
    exp_t e;
    e.instr = instr;
    e.pc    = pc;
    e.comp  = comp;
    exp_q.push_back(e);
  endtask

  // One clock: drive at negedge, evaluate handshakes, release after posedge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    bus.instr_yumi_i = bus.instr_v_o && (int'($urandom_range(99)) < yumi_pct);
    if (word_q.size() > 0 && int'($urandom_range(99)) < fetch_pct) begin
      bus.fetch_v_i    = 1'b1;
      bus.fetch_data_i = word_q[0].data;
      bus.fetch_pc_i   = word_q[0].pc;
    end else begin
      bus.fetch_v_i    = 1'b0;
      bus.fetch_data_i = $urandom;
      bus.fetch_pc_i   = pc_t'({$urandom, $urandom});
    end
    #1;
    if (bus.instr_yumi_i) begin
      fire_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check_eq("unexpected_instr", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        check_eq("instr", 64'(bus.instr_o), 64'(e.instr));
        check_eq("pc", 64'(bus.instr_pc_o), 64'(e.pc));
        check_eq("compressed", 64'(bus.instr_compressed_o), 64'(e.comp));
      end
    end
    if (bus.fetch_v_i && bus.fetch_ready_o) void'(word_q.pop_front());
    @(posedge clk);
    #1;
    quiet();
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (word_q.size() == 0 && exp_q.size() == 0) return;
      step();
    end
    check_eq("drain_timeout", 64'(word_q.size() + exp_q.size()), 64'd0);
  endtask

  // Random RVC/RV32 mix laid out as parcels, then packed into fetch words.
  task automatic gen_stream(input pc_t base, input bit start_hi, input int n);
    logic [15:0] par[$];
    logic [31:0] r;
    logic [1:0]  c;
    pc_t         ipc;
    if (start_hi) par.push_back(16'($urandom));
    repeat (n) begin
      r   = $urandom;
      ipc = base + pc_t'(2 * par.size());
      if ($urandom_range(1) == 1) begin
        par.push_back({r[15:2], 2'b11});
        par.push_back(r[31:16]);
        push_exp({r[31:16], r[15:2], 2'b11}, ipc, 1'b0);
      end else begin
        c = 2'($urandom_range(2));
        par.push_back({r[15:2], c});
        push_exp({16'h0000, r[15:2], c}, ipc, 1'b1);
      end
    end
    if (par.size() % 2 == 1) begin
      ipc = base + pc_t'(2 * par.size());
      par.push_back(16'h0001);
      push_exp(32'h0000_0001, ipc, 1'b1);
    end
    for (int k = 0; k < par.size() / 2; k++)
      push_word({par[2*k+1], par[2*k]},
                (k == 0 && start_hi) ? base + pc_t'(2) : base + pc_t'(4 * k));
  endtask

  // Leaves the DUT in PEND holding 0x00A00513 with the consumer stalled.
  task automatic enter_pend(input pc_t base);
    yumi_pct = 100;
    push_word(32'h0513_4501, base);
    push_exp(32'h0000_4501, base, 1'b1);
    drain(50);
    yumi_pct = 0;
    push_word(32'h1234_00A0, base + pc_t'(4));
    drain(50);
    @(negedge clk);
    check_eq("pend_v", 64'(bus.instr_v_o), 64'd1);
    check_eq("pend_instr", 64'(bus.instr_o), 64'h00A0_0513);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pc_t wb;
    quiet();
    bus.flush_i = 1'b0;

    // Reset held, then released
    repeat (3) @(negedge clk);
    check_eq("reset_ready", 64'(bus.fetch_ready_o), 64'd0);
    check_eq("reset_v", 64'(bus.instr_v_o), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_reset_ready", 64'(bus.fetch_ready_o), 64'd1);
    check_eq("post_reset_v", 64'(bus.instr_v_o), 64'd0);

    // Single 32-bit word
    push_word(32'h00A0_0513, pc_t'('h1000));
    push_exp(32'h00A0_0513, pc_t'('h1000), 1'b0);
    drain(50);
    @(negedge clk);
    check_eq("rv32_ready_after", 64'(bus.fetch_ready_o), 64'd1);
    check_eq("rv32_idle_after", 64'(bus.instr_v_o), 64'd0);

    // Two compressed in one word, back-to-back
    fire_cyc.delete();
    push_word(32'h4505_4501, pc_t'('h2000));
    push_exp(32'h0000_4501, pc_t'('h2000), 1'b1);
    push_exp(32'h0000_4505, pc_t'('h2002), 1'b1);
    drain(50);
    if (fire_cyc.size() >= 2) check_eq("b2b_gap", 64'(fire_cyc[1] - fire_cyc[0]), 64'd1);
    else                      check_eq("b2b_count", 64'(fire_cyc.size()), 64'd2);

    // 32-bit instruction straddling two words
    push_word(32'h0513_4501, pc_t'('h3000));
    push_word(32'h1234_00A0, pc_t'('h3004));
    push_exp(32'h0000_4501, pc_t'('h3000), 1'b1);
    push_exp(32'h00A0_0513, pc_t'('h3002), 1'b0);
    push_exp(32'h0000_1234, pc_t'('h3006), 1'b1);
    drain(50);

    // Entry at pc[1]=1: low half must never appear
    push_word(32'h4505_BEEF, pc_t'('h4002));
    push_exp(32'h0000_4505, pc_t'('h4002), 1'b1);
    drain(50);
    @(negedge clk);
    check_eq("hi_only_idle", 64'(bus.instr_v_o), 64'd0);

    // Flush while holding a pending parcel
    enter_pend(pc_t'('h6000));
    bus.flush_i = 1'b1;
    #1;
    check_eq("flush_v", 64'(bus.instr_v_o), 64'd0);
    check_eq("flush_ready", 64'(bus.fetch_ready_o), 64'd0);
    @(posedge clk);
    #1;
    bus.flush_i = 1'b0;
    @(negedge clk);
    check_eq("post_flush_v", 64'(bus.instr_v_o), 64'd0);
    check_eq("post_flush_ready", 64'(bus.fetch_ready_o), 64'd1);
    yumi_pct = 100;
    push_word(32'h4505_4501, pc_t'('h5000));
    push_exp(32'h0000_4501, pc_t'('h5000), 1'b1);
    push_exp(32'h0000_4505, pc_t'('h5002), 1'b1);
    drain(50);

    // Async reset while holding a pending parcel
    enter_pend(pc_t'('h7000));
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midreset_v", 64'(bus.instr_v_o), 64'd0);
    check_eq("midreset_ready", 64'(bus.fetch_ready_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("midreset_rel_v", 64'(bus.instr_v_o), 64'd0);
    yumi_pct = 100;
    push_word(32'h00A0_0513, pc_t'('h7100));
    push_exp(32'h00A0_0513, pc_t'('h7100), 1'b0);
    drain(50);

    // PC wrap across the top of the address space; zero parcel is compressed
    wb = pc_t'('1) - pc_t'(3);
    push_word(32'h0513_4501, wb);
    push_word(32'h0000_00A0, pc_t'(0));
    push_exp(32'h0000_4501, wb, 1'b1);
    push_exp(32'h00A0_0513, wb + pc_t'(2), 1'b0);
    push_exp(32'h0000_0000, pc_t'(2), 1'b1);
    drain(50);

    // Random streams with gaps, then at full rate
    yumi_pct  = 60;
    fetch_pct = 60;
    gen_stream(pc_t'('h8000), 1'b1, 200);
    drain(5000);
    yumi_pct  = 100;
    fetch_pct = 100;
    gen_stream(pc_t'('h9000), 1'b0, 150);
    drain(2000);
    yumi_pct  = 75;
    fetch_pct = 40;
    gen_stream(pc_t'('hA000), 1'b0, 150);
    drain(5000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_fe_instr_realigner.md
BP_FE_INSTR_REALIGNER -- requirements
Module: bp_fe_instr_realigner

Interface
REQ-001 Parameter: vaddr_width_p, default 39, virtual address width of all PC ports.
REQ-002 Port: clk_i  in  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset_n_i  in  1  asynchronous, active-low reset.
REQ-004 Port: flush_i  in  1  synchronous discard of all buffered parcels (redirect).
REQ-005 Port: fetch_v_i  in  1  fetch word valid.
REQ-006 Port: fetch_data_i  in  32  fetch word; bits [15:0] are the parcel at fetch_pc_i[..:2]*4, bits [31:16] are the parcel at +2.
REQ-007 Port: fetch_pc_i  in  vaddr_width_p  PC of first useful parcel; bit 0 always 0; bit 1 = 1 means only [31:16] is valid.
REQ-008 Port: fetch_ready_o  out  1  word accepted when fetch_v_i & fetch_ready_o.
REQ-009 Port: instr_v_o  out  1  aligned instruction valid.
REQ-010 Port: instr_o  out  32  full instruction, or compressed parcel zero-extended in [15:0].
REQ-011 Port: instr_pc_o  out  vaddr_width_p  PC of instr_o.
REQ-012 Port: instr_compressed_o  out  1  instr_o[1:0] != 2'b11; feeds the RVC expander.
REQ-013 Port: instr_yumi_i  in  1  consumer dequeue; only legal while instr_v_o=1.

Function
REQ-014 Registers: word (32 b), word_pc, pend half (16 b), pend_pc, 2-bit state in {EMPTY, LO, HI, PEND}.
REQ-015 Fetch accept in EMPTY: load word/word_pc; next state HI if fetch_pc_i[1]=1, else LO.
REQ-016 LO, word[1:0]!=11: instr_v_o=1, instr_o={16'b0,word[15:0]}, pc=word_pc, compressed=1; on yumi -> HI.
REQ-017 LO, word[1:0]=11: instr_v_o=1, instr_o=word, pc=word_pc, compressed=0; on yumi -> EMPTY.
REQ-018 HI, word[17:16]!=11: instr_v_o=1, instr_o={16'b0,word[31:16]}, pc=word_pc+2; on yumi -> EMPTY.
REQ-019 HI, word[17:16]=11: instr_v_o=0, fetch_ready_o=1; on fetch accept: pend<=word[31:16], pend_pc<=word_pc+2, word<=fetch_data_i, word_pc<=fetch_pc_i, -> PEND.
REQ-020 PEND: instr_v_o=1, instr_o={word[15:0],pend}, pc=pend_pc, compressed=0; on yumi -> HI.
REQ-021 PEND entry ignores fetch_pc_i[1]; upstream guarantees sequential word (pc[1]=0).
REQ-022 fetch_ready_o=1 in EMPTY, in REQ-019 condition, and combinationally when yumi in REQ-017/REQ-018 would go EMPTY; 0 otherwise.
REQ-023 Simultaneous yumi-to-EMPTY and fetch accept: new word loaded per REQ-015 in same edge; no bubble.
REQ-024 Sustained throughput: one instruction per cycle for any mix of 16/32-bit instructions, except one bubble per HI-uncompressed stall awaiting fetch.
REQ-025 instr_o, instr_pc_o, instr_compressed_o stable while instr_v_o=1 and no yumi.
REQ-026 PC arithmetic modulo 2^vaddr_width_p; word_pc+2 wraps silently.
REQ-027 flush_i=1: instr_v_o=0, fetch_ready_o=0, yumi/fetch ignored; next state EMPTY, pend discarded.
REQ-028 No decode of parcel legality; 16'h0000 passed through as compressed.
REQ-029 Outputs have no combinational path from fetch_data_i/fetch_pc_i; only fetch_ready_o depends on instr_yumi_i.

Reset
REQ-030 reset_n_i low: state EMPTY immediately (async), instr_v_o=0, fetch_ready_o=0, data registers don't-care.
REQ-031 First edge after reset_n_i rises: fetch_ready_o=1, instr_v_o=0.
REQ-032 Reset asserted mid-PEND or mid-handshake: buffered parcels lost, no instruction emitted.

Verification
REQ-033 Word 0x00A0_0513 @0x1000, yumi held -> one instr 0x00A00513 pc 0x1000 compressed=0; next cycle fetch_ready_o=1.
REQ-034 Word 0x4505_4501 @0x2000 -> 0x00004501 pc 0x2000 then 0x00004505 pc 0x2002, both compressed=1, back-to-back cycles.
REQ-035 Word 0x0513_4501 @0x3000, word 0x1234_00A0 @0x3004 -> 0x4501 pc 0x3000, stall, 0x00A00513 pc 0x3002, then HI parcel 0x1234 pc 0x3006 compressed=1.
REQ-036 Word @0x4002 (pc[1]=1) data 0x4505_xxxx -> single 0x00004505 pc 0x4002; low half never emitted.
REQ-037 flush_i in PEND (pend=0x0513) -> instr_v_o=0 that cycle, state EMPTY; next word @0x5000 emitted with no stale parcel.
REQ-038 Random 16/32 stream with random fetch_v_i/yumi gaps vs. reference parcel queue -> every instruction and pc match, order preserved, none dropped/duplicated.
